// File: rtl/enco_pkg.sv
// Shared constants, state encoding and popcount helper for the sequential 8-to-3 encoder.
// Popcount support is only used when ENC_POPCNT_EN is defined.
package enco_pkg;

  localparam int N_IN  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_IN-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/enco_prio_comb.sv
// Combinational priority finder: highest set bit index, any-bit-set flag,
// and exactly-one-bit-set flag.
module enco_prio_comb
  import enco_pkg::*;
(
  input  logic [N_IN-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             single
);

  always_comb begin
    idx = '0;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < N_IN; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign found  = |vec;
  assign single = found && ((vec & (vec - N_IN'(1))) == '0);

endmodule

// File: rtl/enco_8x3_seq.sv
// Sequential 8-to-3 encoder: accepts a request vector, emits one index per beat,
// highest first. Optional macro ENC_POPCNT_EN adds out_cnt (popcount of the vector).
module enco_8x3_seq
  import enco_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
`ifdef ENC_POPCNT_EN
  ,
  output logic [CNT_W-1:0] out_cnt
`endif
);

  state_t            state;
  logic [N_IN-1:0]   pend;
  logic [N_IN-1:0]   pend_d;
  logic [N_IN-1:0]   clr_mask;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_found;
  logic              nxt_single;

  // pend_d is what pend becomes on an accept or a taken beat; decoding it here
  // lets the next beat's fields be registered in the same edge.
  assign clr_mask = {{(N_IN-1){1'b0}}, 1'b1} << out_idx;

  always_comb begin
    pend_d = pend;
    if (state == IDLE) begin
      pend_d = in_vec;
    end else begin
      pend_d = pend & ~clr_mask;
    end
  end

  enco_prio_comb u_prio (
    .vec    (pend_d),
    .idx    (nxt_idx),
    .found  (nxt_found),
    .single (nxt_single)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= EMIT;
            pend      <= pend_d;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_idx   <= nxt_idx;
            out_last  <= nxt_single || !nxt_found;
            out_none  <= !nxt_found;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              pend      <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              out_none  <= 1'b0;
            end else begin
              pend      <= pend_d;
              out_idx   <= nxt_idx;
              out_last  <= nxt_single;
              out_none  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ENC_POPCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      out_cnt <= popcnt(in_vec);
    end
  end
`endif

endmodule
